branch_pred_ctrl: RTL and testbench

Dynamic branch predictor and mispredict-recovery controller for the pipelined RV32 core. Holds a direct-mapped branch target buffer with 2-bit saturating counters, supplies a taken/target prediction to IF every cycle, and receives resolution from EX, where the branch-select logic evaluates the condition flags. On a mispredict it issues the redirect PC and the pipeline flush, then trains the table. It replaces the static not-taken policy, under which every taken branch costs a flush.

---
 rtl/branch_pred_ctrl_pkg.sv | 21 ++
 rtl/branch_pred_ctrl_sat_counter2.sv | 27 ++
 rtl/branch_pred_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_pred_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared definitions for the branch predictor: address width, default BTB
// size, 2-bit counter encodings and recovery FSM states.
package branch_pred_ctrl_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned BTB_IDX_W_DEF = 4;

  // 2-bit saturating counter encodings; MSB set means predict taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/branch_pred_ctrl_sat_counter2.sv
// sat_counter2: 2-bit saturating up/down counter next-state logic.
// Ports:
//   ctr        current counter value
//   en         apply the update
//   up         1 = count toward 11, 0 = count toward 00
//   ctr_next_c next counter value (combinational)
module sat_counter2
  import branch_pred_ctrl_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       en,
  input  logic       up,
  output logic [1:0] ctr_next_c
);

  always_comb begin
    ctr_next_c = ctr;
    if (en) begin
      if (up) begin
        if (ctr != 2'(ST)) ctr_next_c = ctr + 2'd1;
      end else begin
        if (ctr != 2'(SNT)) ctr_next_c = ctr - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: direct-mapped BTB with 2-bit counters, IF prediction,
// EX mispredict detection/redirect and one-cycle recovery FSM.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_pc                        fetch PC for lookup
//   pred_taken, pred_target      same-cycle prediction to IF
//   ex_valid, ex_stall,
//   ex_is_branch, ex_pc,
//   ex_taken, ex_target,
//   ex_pred_taken, ex_pred_target  resolution info from EX
//   mispredict, redirect_pc      same-cycle flush and correct next PC
//   stat_branches,
//   stat_mispredicts             saturating counters (BRANCH_PRED_STATS_EN only)
// Build option: define BRANCH_PRED_STATS_EN to add the statistics counters.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W   = XLEN - BTB_IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  state_e             state_q, state_d;

  logic [BTB_IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;
  logic                 if_hit, ex_hit, res, mispredict_raw;
  logic [1:0]           ctr_upd;
  logic                 unused_if_pc_lo;

  assign if_idx = if_pc[BTB_IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:BTB_IDX_W+2];
  assign ex_idx = ex_pc[BTB_IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:BTB_IDX_W+2];
  assign unused_if_pc_lo = ^if_pc[1:0];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A stalled or bubbled EX slot never resolves, so it can neither flush nor train.
  assign res = ex_valid & ex_is_branch & ~ex_stall;
  assign mispredict_raw = res & ((ex_taken != ex_pred_taken) |
                                 (ex_taken & (ex_pred_target != ex_target)));

  // Single write port, so one counter-update instance serves the whole table.
  sat_counter2 u_sat_counter2 (
    .ctr        (ctr_q[ex_idx]),
    .en         (1'b1),
    .up         (ex_taken),
    .ctr_next_c (ctr_upd)
  );

  // Table training; lookups this cycle still see the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= '{default: 2'(WNT)};
    end else if (res) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_upd;
        if (ex_taken) tgt_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= ex_target;
        ctr_q[ex_idx]   <= 2'(WT);
      end
    end
  end

  // Recovery FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= NORMAL;
    else     state_q <= state_d;
  end

  // Next state and outputs; reset forces outputs to their idle values.
  always_comb begin
    state_d     = state_q;
    pred_taken  = 1'b0;
    pred_target = '0;
    mispredict  = 1'b0;
    redirect_pc = ex_pc + XLEN'(4);
    if (!rst) begin
      if (if_hit) begin
        pred_target = tgt_q[if_idx];
        // IF is fetching redirect_pc during RECOVER, so suppress taken.
        pred_taken  = ctr_q[if_idx][1] && (state_q == NORMAL);
      end
      mispredict = mispredict_raw;
      if (ex_taken) redirect_pc = ex_target;
      state_d = mispredict_raw ? RECOVER : NORMAL;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  // Saturating resolution/mispredict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res && (stat_branches != '1))             stat_branches    <= stat_branches + 32'd1;
      if (mispredict_raw && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl; expected outputs are queued as
// each stimulus row is driven and popped when the outputs are sampled.
module tb_branch_pred_ctrl;
  import branch_pred_ctrl_pkg::*;

  typedef struct {
    logic        r;
    logic [31:0] ipc;
    logic        v;
    logic        st;
    logic [31:0] epc;
    logic        tk;
    logic [31:0] etg;
    logic        ept;
    logic [31:0] eptg;
  } stim_t;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic        ex_stall = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  localparam logic [31:0] ALIAS_PC = 32'h100 + (32'd4 << BTB_IDX_W_DEF);

  branch_pred_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  function automatic stim_t idle(input logic [31:0] ipc, input logic r);
    idle = '{r: r, ipc: ipc, v: 1'b0, st: 1'b0, epc: 32'h0, tk: 1'b0,
             etg: 32'h0, ept: 1'b0, eptg: 32'h0};
  endfunction

  function automatic stim_t br(input logic [31:0] ipc, input logic [31:0] epc,
                               input logic tk, input logic [31:0] etg,
                               input logic ept, input logic [31:0] eptg,
                               input logic st, input logic r);
    br = '{r: r, ipc: ipc, v: 1'b1, st: st, epc: epc, tk: tk,
           etg: etg, ept: ept, eptg: eptg};
  endfunction

  function automatic exp_t ex(input logic pt, input logic [31:0] ptgt,
                              input logic mp, input logic [31:0] rpc);
    ex = '{pt: pt, ptgt: ptgt, mp: mp, rpc: rpc};
  endfunction

  task automatic apply(input stim_t s);
    rst            = s.r;
    if_pc          = s.ipc;
    ex_valid       = s.v;
    ex_is_branch   = s.v;
    ex_stall       = s.st;
    ex_pc          = s.epc;
    ex_taken       = s.tk;
    ex_target      = s.etg;
    ex_pred_taken  = s.ept;
    ex_pred_target = s.eptg;
  endtask

  // Assert rst for one edge; the next row's edge performs the reset.
  task automatic do_reset();
    @(posedge clk); #1;
    apply(idle(32'h0, 1'b1));
  endtask

  task automatic test_reset();
    stim_t s[2]; exp_t e[2]; exp_t got;
    s[0] = idle(32'h100, 1'b1); e[0] = ex(1'b0, 32'h0, 1'b0, 32'h4);
    s[1] = idle(32'h100, 1'b0); e[1] = ex(1'b0, 32'h0, 1'b0, 32'h4);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL reset[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
  endtask

  task automatic test_allocate();
    stim_t s[3]; exp_t e[3]; exp_t got;
    do_reset();
    s[0] = br(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0); e[0] = ex(1'b0, 32'h0, 1'b1, 32'h80);
    s[1] = idle(32'h100, 1'b0);                                        e[1] = ex(1'b0, 32'h80, 1'b0, 32'h4);
    s[2] = idle(32'h100, 1'b0);                                        e[2] = ex(1'b1, 32'h80, 1'b0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL allocate[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t s[7]; exp_t e[7]; exp_t got;
    do_reset();
    s[0] = br(32'h0,   32'h200, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0); e[0] = ex(1'b0, 32'h0,   1'b1, 32'h300);
    s[1] = br(32'h0,   32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0); e[1] = ex(1'b0, 32'h0,   1'b0, 32'h300);
    s[2] = br(32'h0,   32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0); e[2] = ex(1'b0, 32'h0,   1'b0, 32'h300);
    s[3] = idle(32'h200, 1'b0);                                            e[3] = ex(1'b1, 32'h300, 1'b0, 32'h4);
    s[4] = br(32'h200, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0); e[4] = ex(1'b1, 32'h300, 1'b1, 32'h204);
    s[5] = idle(32'h200, 1'b0);                                            e[5] = ex(1'b0, 32'h300, 1'b0, 32'h4);
    s[6] = idle(32'h200, 1'b0);                                            e[6] = ex(1'b1, 32'h300, 1'b0, 32'h4);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL saturate[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
`ifdef BRANCH_PRED_STATS_EN
    checks++;
    if ({stat_branches, stat_mispredicts} !== {32'd4, 32'd2}) begin
      failures++;
      $display("FAIL stats_count got br=%0d mp=%0d want br=4 mp=2", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_alias();
    stim_t s[5]; exp_t e[5]; exp_t got;
    do_reset();
    s[0] = br(32'h100, 32'h100,  1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0); e[0] = ex(1'b0, 32'h0,  1'b1, 32'h80);
    s[1] = idle(32'h100, 1'b0);                                          e[1] = ex(1'b0, 32'h80, 1'b0, 32'h4);
    s[2] = br(32'h100, ALIAS_PC, 1'b1, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b0); e[2] = ex(1'b1, 32'h80, 1'b1, 32'hA0);
    s[3] = idle(32'h100, 1'b0);                                          e[3] = ex(1'b0, 32'h0,  1'b0, 32'h4);
    s[4] = idle(ALIAS_PC, 1'b0);                                         e[4] = ex(1'b1, 32'hA0, 1'b0, 32'h4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL alias[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
  endtask

  task automatic test_target_change();
    stim_t s[6]; exp_t e[6]; exp_t got;
    do_reset();
    s[0] = br(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 1'b0); e[0] = ex(1'b0, 32'h0,  1'b1, 32'h80);
    s[1] = idle(32'h100, 1'b0);                                         e[1] = ex(1'b0, 32'h80, 1'b0, 32'h4);
    s[2] = idle(32'h100, 1'b0);                                         e[2] = ex(1'b1, 32'h80, 1'b0, 32'h4);
    s[3] = br(32'h100, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b0, 1'b0); e[3] = ex(1'b1, 32'h80, 1'b1, 32'h90);
    s[4] = idle(32'h100, 1'b0);                                         e[4] = ex(1'b0, 32'h90, 1'b0, 32'h4);
    s[5] = idle(32'h100, 1'b0);                                         e[5] = ex(1'b1, 32'h90, 1'b0, 32'h4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL target_change[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
  endtask

  task automatic test_stall_recover();
    stim_t s[6]; exp_t e[6]; exp_t got;
    do_reset();
    s[0] = br(32'h4,   32'h100, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 1'b0); e[0] = ex(1'b0, 32'h0,  1'b1, 32'h80);
    s[1] = br(32'h4,   32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0); e[1] = ex(1'b0, 32'h0,  1'b0, 32'h80);
    s[2] = br(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0); e[2] = ex(1'b1, 32'h80, 1'b0, 32'h104);
    s[3] = br(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0); e[3] = ex(1'b1, 32'h80, 1'b1, 32'h104);
    s[4] = idle(32'h100, 1'b0);                                         e[4] = ex(1'b0, 32'h80, 1'b0, 32'h4);
    s[5] = idle(32'h100, 1'b0);                                         e[5] = ex(1'b1, 32'h80, 1'b0, 32'h4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL stall_recover[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
  endtask

  // Entry 0x100 is still live from the previous test when rst arrives.
  task automatic test_reset_mid();
    stim_t s[3]; exp_t e[3]; exp_t got;
    s[0] = br(32'h100, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b1); e[0] = ex(1'b0, 32'h0, 1'b0, 32'h304);
    s[1] = idle(32'h300, 1'b0);                                          e[1] = ex(1'b0, 32'h0, 1'b0, 32'h4);
    s[2] = idle(32'h100, 1'b0);                                          e[2] = ex(1'b0, 32'h0, 1'b0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); got = exp_q.pop_front(); checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== {got.pt, got.ptgt, got.mp, got.rpc}) begin
        failures++;
        $display("FAIL reset_mid[%0d] got pt=%b tgt=%h mp=%b rpc=%h want pt=%b tgt=%h mp=%b rpc=%h",
                 i, pred_taken, pred_target, mispredict, redirect_pc, got.pt, got.ptgt, got.mp, got.rpc);
      end
    end
`ifdef BRANCH_PRED_STATS_EN
    checks++;
    if ({stat_branches, stat_mispredicts} !== 64'h0) begin
      failures++;
      $display("FAIL stats_reset got br=%0d mp=%0d want br=0 mp=0", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturate();
    test_alias();
    test_target_change();
    test_stall_recover();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
